// File: rtl/cpu_beat_gen.sv
// Beat (W-phase) timing generator for the hard-wired cpu controller: sequences W1/W2/W3 per short/long/stop.
// Optional BEAT_SINGLE_STEP_EN adds step_mode, which forces a halt after every machine cycle.
module cpu_beat_gen #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 t3,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 short,
  input  logic                 long,
  input  logic                 stop,
`ifdef BEAT_SINGLE_STEP_EN
  input  logic                 step_mode,
`endif
  output logic                 w1,
  output logic                 w2,
  output logic                 w3,
  output logic                 running,
  output logic                 cycle_end,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;

  state_t state, state_nxt;
  logic   halt;

`ifdef BEAT_SINGLE_STEP_EN
  assign halt = stop | step_mode;
`else
  assign halt = stop;
`endif

  always_comb begin
    cycle_end = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = W1;
      W1:   if (short) cycle_end = 1'b1;
            else       state_nxt = W2;
      W2:   if (long)  state_nxt = W3;
            else       cycle_end = 1'b1;
      W3:   cycle_end = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // stop is only honoured on the final beat, and it overrides start there
    if (cycle_end) state_nxt = halt ? IDLE : W1;
  end

  // Beat outputs are registered copies of the next-state decode, so they track state exactly
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      w1        <= 1'b0;
      w2        <= 1'b0;
      w3        <= 1'b0;
      running   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state   <= state_nxt;
      w1      <= (state_nxt == W1);
      w2      <= (state_nxt == W2);
      w3      <= (state_nxt == W3);
      running <= (state_nxt != IDLE);
      if (cycle_end) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/cpu_beat_gen.md
Name: cpu_beat_gen

Overview:
- Beat (W-phase) timing generator that drives the w1/w2/w3 inputs of the hard-wired `cpu` controller.
- Responds to the controller's short/long/stop requests. Replaces the free-running beat stimulus with synthesizable RTL.
- Sits beside `cpu` in the top level:
  - Clocked by t3 and reset by clr.
  - Outputs go to cpu.w1/w2/w3.
  - Inputs come from cpu.short/long/stop.

Parameters:
- CNT_WIDTH, 8: width of the completed-machine-cycle counter.

Ports:
- t3  input  1  clock; all state updates on rising edge.
- clr  input  1  asynchronous active-low reset; 0 forces IDLE immediately.
- start  input  1  run request (QD button, already debounced); level, sampled on t3 rise.
- short  input  1  from cpu; current machine cycle is one beat (honoured in W1).
- long  input  1  from cpu; current machine cycle is three beats (honoured in W2).
- stop  input  1  from cpu; halt after the current machine cycle.
- w1  output  1  beat 1 active, registered.
- w2  output  1  beat 2 active, registered.
- w3  output  1  beat 3 active, registered.
- running  output  1  high in W1/W2/W3, low in IDLE, registered.
- cycle_end  output  1  combinational; high during the last beat of the current machine cycle.
- cycle_cnt  output  CNT_WIDTH  count of completed machine cycles since reset.

Behaviour:
- State register: IDLE, W1, W2, W3.
  - Outputs w1/w2/w3 decode the state one-hot; all are 0 in IDLE.
  - Never more than one wN high.
- Reset (clr=0, asynchronous): state=IDLE; w1=w2=w3=0; running=0; cycle_cnt=0. Holds while clr=0, including mid-beat.
- On release, the first action occurs on the first t3 rise with clr=1.
- IDLE:
  - start=1 -> W1 (w1 high one cycle after the sampling edge); otherwise stay.
  - short/long/stop are ignored in IDLE.
- W1:
  - short=1 -> end of cycle; short has priority over long if both are high.
  - Otherwise -> W2.
- W2:
  - long=1 -> W3.
  - Otherwise -> end of cycle.
- W3: always end of cycle.
- End of cycle: cycle_end = (W1&short) | (W2&~long) | W3.
  - On the t3 rise while cycle_end=1, cycle_cnt increments.
  - Then: stop=1 -> IDLE; else -> W1 (next machine cycle starts immediately, no gap beat).
- Sampling rules:
  - stop is sampled only on the cycle_end edge; stop in non-final beats has no effect.
  - start is ignored while running.
  - start=1 and stop=1 on the same final-beat edge -> IDLE (stop wins). A later start restarts.
- cycle_cnt wraps from 2^CNT_WIDTH-1 to 0 without flag.
- short/long/stop are combinational from cpu and must be settled before the t3 rise. No internal synchronization; all three are in the t3 domain.
- Latency: start edge -> w1 on next cycle. Final-beat edge -> next W1 or IDLE on the following cycle.
- running = (state != IDLE).

Optional Feature:
- Macro: BEAT_SINGLE_STEP_EN.
- Defined:
  - Adds input `step_mode` (1 bit).
  - When step_mode=1, every end of cycle goes to IDLE regardless of stop, so each start runs exactly one machine cycle. cycle_cnt still increments.
  - When step_mode=0, behaviour is as if the feature were absent.
- Undefined: port absent; behaviour exactly as in Behaviour.

Test Plan:
- Reset mid-W2: run with short=0, long=0, pull clr=0 during W2 -> w1/w2/w3=0, running=0, cycle_cnt=0 immediately without a clock edge. After release, stays IDLE until start.
- Short cycles: start=1 one cycle, short=1, long=0, stop=0 -> w1 high every cycle, w2/w3 never high. After 5 cycles cycle_cnt=5.
- Mixed sequence: short=0; long=0 for the first cycle, long=1 for the second -> beats W1,W2 then W1,W2,W3. cycle_end high in the 2nd and 5th beats; cycle_cnt=2.
- Stop handling: stop=1 during W1 of a long cycle (dropped by W3) -> no halt, continues W1. stop=1 held through W3 -> IDLE next cycle, running=0, cycle_cnt incremented once.
- Priority and wrap:
  - short=1 and long=1 in W1 -> single-beat cycle, no W2.
  - CNT_WIDTH=2 with 4 cycles -> cycle_cnt returns to 0.
  - start+stop on a final beat -> IDLE.
- BEAT_SINGLE_STEP_EN with step_mode=1, stop=0, two-beat cycles: each start pulse yields exactly W1,W2 then IDLE. Three pulses -> cycle_cnt=3.
